// File: rtl/tx_ordered_set_ctrl.sv
// ============================================================================
// Module  : tx_ordered_set_ctrl
// Brief   : 1000BASE-X style TX ordered-set sequencer (idle, /S/, data, /T/, /R/).
//           Optional macro TX_ERR_PROP_EN: TX_ER during data emits /V/.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tx_ordered_set_ctrl #(
    parameter int PKT_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 RESET,
    input  logic [7:0]           TXD,
    input  logic                 TX_EN,
    input  logic                 TX_ER,
    output logic                 tx_ready,
    output logic [7:0]           tx_octet,
    output logic                 tx_is_k,
    output logic                 tx_even,
    output logic [PKT_CNT_W-1:0] tx_pkt_cnt
);

    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] D16_2 = 8'h50;
    localparam logic [7:0] K27_7 = 8'hFB;
    localparam logic [7:0] K29_7 = 8'hFD;
    localparam logic [7:0] K23_7 = 8'hF7;

    typedef enum logic [2:0] {
        S_IDLE_K = 3'd0,
        S_IDLE_D = 3'd1,
        S_SOP    = 3'd2,
        S_DATA   = 3'd3,
        S_EPD_R1 = 3'd4,
        S_EPD_R2 = 3'd5
    } state_t;

    state_t state;
    logic   parity_even;

`ifndef TX_ERR_PROP_EN
    logic unused_tx_er;
    assign unused_tx_er = TX_ER;
`endif

    assign tx_ready = (state == S_DATA);

    always_ff @(posedge clk) begin
        if (RESET) begin
            state       <= S_IDLE_K;
            parity_even <= 1'b1;
            tx_octet    <= D16_2;
            tx_is_k     <= 1'b0;
            tx_even     <= 1'b0;
            tx_pkt_cnt  <= '0;
        end else begin
            tx_even     <= parity_even;
            parity_even <= ~parity_even;
            case (state)
                S_IDLE_K: begin
                    tx_octet <= K28_5;
                    tx_is_k  <= 1'b1;
                    state    <= S_IDLE_D;
                end
                S_IDLE_D: begin
                    tx_octet <= D16_2;
                    tx_is_k  <= 1'b0;
                    state    <= TX_EN ? S_SOP : S_IDLE_K;
                end
                S_SOP: begin
                    tx_octet <= K27_7;
                    tx_is_k  <= 1'b1;
                    state    <= S_DATA;
                end
                S_DATA: begin
                    if (TX_EN) begin
`ifdef TX_ERR_PROP_EN
                        tx_octet <= TX_ER ? 8'hFE : TXD;
                        tx_is_k  <= TX_ER;
`else
                        tx_octet <= TXD;
                        tx_is_k  <= 1'b0;
`endif
                        state    <= S_DATA;
                    end else begin
                        tx_octet   <= K29_7;
                        tx_is_k    <= 1'b1;
                        tx_pkt_cnt <= tx_pkt_cnt + 1'b1;
                        state      <= S_EPD_R1;
                    end
                end
                S_EPD_R1: begin
                    // A second /R/ is needed only when the next K28.5 would land odd
                    tx_octet <= K23_7;
                    tx_is_k  <= 1'b1;
                    state    <= parity_even ? S_EPD_R2 : S_IDLE_K;
                end
                S_EPD_R2: begin
                    tx_octet <= K23_7;
                    tx_is_k  <= 1'b1;
                    state    <= S_IDLE_K;
                end
                default: begin
                    tx_octet <= D16_2;
                    tx_is_k  <= 1'b0;
                    state    <= S_IDLE_K;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/tx_ordered_set_ctrl.md
TX_ORDERED_SET_CTRL -- requirements
Module: tx_ordered_set_ctrl

Interface
REQ-001 SHALL have parameter: PKT_CNT_W, 16, width of completed-packet counter.
REQ-002 SHALL have port: clk  input  1  single clock, all logic on rising edge.
REQ-003 SHALL have port: RESET  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: TXD  input  8  transmit data octet from MAC.
REQ-005 SHALL have port: TX_EN  input  1  frame valid; held high from frame start until last octet consumed.
REQ-006 SHALL have port: TX_ER  input  1  transmit error, qualified by TX_EN.
REQ-007 SHALL have port: tx_ready  output  1  high exactly in DATA state; octet consumed on an edge where tx_ready=1 and TX_EN=1.
REQ-008 SHALL have port: tx_octet  output  8  registered code-group octet to 8b/10b encoder.
REQ-009 SHALL have port: tx_is_k  output  1  registered; 1 = control code group (K), 0 = data (D).
REQ-010 SHALL have port: tx_even  output  1  registered; 1 = code group occupies even position.
REQ-011 SHALL have port: tx_pkt_cnt  output  PKT_CNT_W  count of packets terminated with /T/.

Function
REQ-012 SHALL implement states IDLE_K, IDLE_D, SOP, DATA, EPD_R1, EPD_R2.
REQ-013 SHALL, on every non-reset edge, load outputs with the code group of the pre-edge state and advance state; latency TXD acceptance -> tx_octet = 1 clk.
REQ-014 SHALL toggle a position-parity register every non-reset edge; tx_even takes its pre-edge value.
REQ-015 IDLE_K SHALL emit K28.5 (8'hBC, k=1) and go to IDLE_D; TX_EN ignored here.
REQ-016 IDLE_D SHALL emit D16.2 (8'h50, k=0); next SOP if TX_EN=1, else IDLE_K.
REQ-017 SOP SHALL emit /S/ K27.7 (8'hFB, k=1), tx_ready=0, and go to DATA; SOP always lands on even position.
REQ-018 DATA with TX_EN=1 SHALL emit TXD (k=0), consume it, stay in DATA.
REQ-019 DATA with TX_EN=0 SHALL emit /T/ K29.7 (8'hFD, k=1), increment tx_pkt_cnt, go to EPD_R1; zero-length frame (TX_EN low on first DATA cycle) allowed.
REQ-020 EPD_R1 SHALL emit /R/ K23.7 (8'hF7, k=1); next IDLE_K if EPD_R1 was odd, else EPD_R2.
REQ-021 EPD_R2 SHALL emit /R/ (8'hF7, k=1) and go to IDLE_K, guaranteeing K28.5 on even position.
REQ-022 tx_pkt_cnt SHALL wrap from all-ones to 0 without saturation.
REQ-023 Unreachable state encodings SHALL recover to IDLE_K on next edge.

Reset
REQ-024 RESET=1 SHALL force state IDLE_K, parity even, tx_octet=8'h50, tx_is_k=0, tx_even=0, tx_pkt_cnt=0, tx_ready=0.
REQ-025 RESET mid-frame SHALL abandon the frame immediately without /T/ or /R/, and without counting it.
REQ-026 First edge after RESET release SHALL output 8'hBC, tx_is_k=1, tx_even=1.

Configuration
REQ-027 With TX_ERR_PROP_EN defined, DATA with TX_EN=1 and TX_ER=1 SHALL emit /V/ K30.7 (8'hFE, k=1) in place of TXD, octet still consumed.
REQ-028 Without TX_ERR_PROP_EN, TX_ER SHALL be ignored and TXD emitted as data.

Verification
REQ-029 Reset 3 clk, release, TX_EN=0 -> tx_octet BC,50,BC,50... with tx_is_k 1,0,1,0 and tx_even 1,0,1,0.
REQ-030 Frame of 3 octets 11,22,33 -> FB,11,22,33,FD,F7,BC; tx_pkt_cnt 0->1.
REQ-031 Frame of 2 octets 11,22 -> FB,11,22,FD,F7,F7,BC; BC on tx_even=1.
REQ-032 TX_EN raised during IDLE_K cycle -> one extra 50 emitted before FB; no octet lost.
REQ-033 TX_ERR_PROP_EN defined, TX_ER=1 on 2nd of 3 octets -> FB,11,FE,33,FD,F7,BC; undefined -> FB,11,22,33,FD,F7,BC.
REQ-034 RESET asserted after FB,11 of a frame -> outputs 50/k=0, tx_pkt_cnt=0; preset tx_pkt_cnt=FFFF plus one frame -> 0000.
